// File: rtl/rv32i_pkg.sv
// Shared sizing for the rename free-list slice: tag widths, list depth and the
// record that describes one tag being handed back to the free list.
package rv32i_pkg;
    localparam int PHYS_REG_FILE_IDX_BW = 6;
    localparam int ARCH_REG_FILE_IDX_BW = 5;
    localparam int FREE_LIST_DEPTH      = 2**PHYS_REG_FILE_IDX_BW - 2**ARCH_REG_FILE_IDX_BW;

    typedef struct packed {
        logic                            vld;
        logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
    } tag_push_t;
endpackage

// File: rtl/rv32i_tag_fifo.sv
// Circular tag FIFO with wrap-bit pointers; reset preloads BASE..BASE+DEPTH-1 so
// the list starts full of the physical tags no architectural register owns.
module rv32i_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 6,
    parameter int CNT_W = 7,
    parameter int BASE  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [W-1:0]     push_tag,
    input  logic             pop,
    output logic [W-1:0]     head_tag,
    output logic [CNT_W-1:0] cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  rd_ptr, wr_ptr;
    logic         do_pop, do_push, full;

    function automatic logic [AW:0] next_ptr(input logic [AW:0] p);
        // Explicit wrap keeps non power-of-two depths correct.
        if (p[AW-1:0] == AW'(DEPTH-1)) return {~p[AW], {AW{1'b0}}};
        return p + 1'b1;
    endfunction

    assign full     = (cnt == CNT_W'(DEPTH));
    assign do_pop   = pop && (cnt != '0);
    assign do_push  = push && (!full || do_pop);
    assign head_tag = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= W'(BASE + i);
            rd_ptr <= '0;
            wr_ptr <= {1'b1, {AW{1'b0}}};
            cnt    <= CNT_W'(DEPTH);
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_tag;
                wr_ptr              <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    // A push into a full list with no pop means a tag was duplicated upstream.
    assert property (@(posedge clk) disable iff (!rstn) !(push && full && !do_pop));
endmodule

// File: rtl/rv32i_phys_reg_free_list.sv
// Physical register free list: hands out free tags to dispatch and, at retire,
// recycles the tag the retiring write supersedes via the retirement RAT.
module rv32i_phys_reg_free_list
    import rv32i_pkg::*;
#(
    parameter int PHYS_REG_FILE_DEPTH = 2**PHYS_REG_FILE_IDX_BW,
    parameter int ARCH_REG_FILE_DEPTH = 2**ARCH_REG_FILE_IDX_BW
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_alloc_req,
    output logic                            o_alloc_vld,
    output logic [PHYS_REG_FILE_IDX_BW-1:0] o_alloc_tag,
    input  logic                            i_retire,
    input  logic                            i_retire_dst_vld,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_retire_dst_phys_rf_tag,
    input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_retire_dst_arch_rf_idx,
    output logic                            o_freed_vld,
    output logic [PHYS_REG_FILE_IDX_BW-1:0] o_freed_tag,
    output logic [PHYS_REG_FILE_IDX_BW:0]   o_free_cnt
);
    localparam int FL_DEPTH = PHYS_REG_FILE_DEPTH - ARCH_REG_FILE_DEPTH;

    logic [PHYS_REG_FILE_IDX_BW-1:0] rrat [ARCH_REG_FILE_DEPTH];
    logic                            retire_wr, arch_nz, alloc_fire;
    tag_push_t                       push;

    assign retire_wr  = i_retire && i_retire_dst_vld;
    assign arch_nz    = (i_retire_dst_arch_rf_idx != '0);
    assign alloc_fire = i_alloc_req && o_alloc_vld;
    assign o_alloc_vld = (o_free_cnt != '0);

    // x0 never holds a mapping, so its "new" tag goes straight back to the list.
    always_comb begin
        push.vld = retire_wr;
        push.tag = arch_nz ? rrat[i_retire_dst_arch_rf_idx] : i_retire_dst_phys_rf_tag;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ARCH_REG_FILE_DEPTH; i++)
                rrat[i] <= PHYS_REG_FILE_IDX_BW'(i);
        end else if (retire_wr && arch_nz) begin
            rrat[i_retire_dst_arch_rf_idx] <= i_retire_dst_phys_rf_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_freed_vld <= 1'b0;
            o_freed_tag <= '0;
        end else begin
            o_freed_vld <= push.vld;
            if (push.vld) o_freed_tag <= push.tag;
        end
    end

    rv32i_tag_fifo #(
        .DEPTH (FL_DEPTH),
        .W     (PHYS_REG_FILE_IDX_BW),
        .CNT_W (PHYS_REG_FILE_IDX_BW + 1),
        .BASE  (ARCH_REG_FILE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push.vld),
        .push_tag (push.tag),
        .pop      (alloc_fire),
        .head_tag (o_alloc_tag),
        .cnt      (o_free_cnt)
    );
endmodule

// File: tb/tb_rv32i_phys_reg_free_list.sv
// Bench for the free list: queue-based model (free list, RRAT array, in-flight
// tags) compared every cycle, plus literal expectations for the key scenarios.
module tb_rv32i_phys_reg_free_list;
    logic       clk = 1'b0;
    logic       rstn;
    logic       i_alloc_req, i_retire, i_retire_dst_vld;
    logic [5:0] i_retire_dst_phys_rf_tag;
    logic [4:0] i_retire_dst_arch_rf_idx;
    logic       o_alloc_vld, o_freed_vld;
    logic [5:0] o_alloc_tag, o_freed_tag;
    logic [6:0] o_free_cnt;

    int checks = 0, failures = 0;

    // model state
    int fl[$];
    int infl[$];
    int rrat[32];
    bit exp_fv;
    int exp_ft;

    rv32i_phys_reg_free_list dut (
        .clk(clk), .rstn(rstn),
        .i_alloc_req(i_alloc_req), .o_alloc_vld(o_alloc_vld), .o_alloc_tag(o_alloc_tag),
        .i_retire(i_retire), .i_retire_dst_vld(i_retire_dst_vld),
        .i_retire_dst_phys_rf_tag(i_retire_dst_phys_rf_tag),
        .i_retire_dst_arch_rf_idx(i_retire_dst_arch_rf_idx),
        .o_freed_vld(o_freed_vld), .o_freed_tag(o_freed_tag), .o_free_cnt(o_free_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        infl.delete();
        for (int i = 0; i < 32; i++) begin
            rrat[i] = i;
            fl.push_back(32 + i);
        end
        exp_fv = 0;
        exp_ft = 0;
    endtask

    task automatic compare_model();
        chk("alloc_vld", o_alloc_vld, fl.size() != 0);
        if (fl.size() != 0) chk("alloc_tag", o_alloc_tag, fl[0]);
        chk("free_cnt", o_free_cnt, fl.size());
        chk("freed_vld", o_freed_vld, exp_fv);
        if (exp_fv) chk("freed_tag", o_freed_tag, exp_ft);
    endtask

    // One clock: drive at negedge, compare, let the edge happen, advance model.
    task automatic step(input bit a, input bit r, input bit dv, input int ptag, input int aidx);
        bit fire;
        @(negedge clk);
        i_alloc_req              = a;
        i_retire                 = r;
        i_retire_dst_vld         = dv;
        i_retire_dst_phys_rf_tag = 6'(ptag);
        i_retire_dst_arch_rf_idx = 5'(aidx);
        #1;
        compare_model();
        @(posedge clk);
        fire = a && (fl.size() != 0);
        if (fire) infl.push_back(fl.pop_front());
        if (r && dv) begin
            exp_fv = 1;
            if (aidx != 0) begin
                exp_ft     = rrat[aidx];
                rrat[aidx] = ptag;
            end else begin
                exp_ft = ptag;
            end
            fl.push_back(exp_ft);
            for (int k = 0; k < infl.size(); k++)
                if (infl[k] == ptag) begin
                    infl.delete(k);
                    break;
                end
        end else begin
            exp_fv = 0;
        end
        #1;
        i_alloc_req = 0; i_retire = 0; i_retire_dst_vld = 0;
    endtask

    task automatic retire_inflight(input bit a);
        int k;
        if (infl.size() == 0) begin
            step(a, 0, 0, 0, 0);
        end else begin
            k = $urandom_range(0, infl.size() - 1);
            step(a, 1, 1, infl[k], $urandom_range(0, 31));
        end
    endtask

    initial begin
        rstn = 0;
        i_alloc_req = 0; i_retire = 0; i_retire_dst_vld = 0;
        i_retire_dst_phys_rf_tag = 0; i_retire_dst_arch_rf_idx = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_free_cnt", o_free_cnt, 32);
        chk("rst_alloc_vld", o_alloc_vld, 1);
        chk("rst_alloc_tag", o_alloc_tag, 32);
        chk("rst_freed_vld", o_freed_vld, 0);
        @(negedge clk) rstn = 1;

        // drain: 32..63 in order, then empty
        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", o_alloc_tag, 32 + i);
            step(1, 0, 0, 0, 0);
        end
        chk("empty_vld", o_alloc_vld, 0);
        chk("empty_cnt", o_free_cnt, 0);

        // alloc on empty list with same-cycle retire freeing tag 7: no bypass
        step(1, 1, 1, 42, 7);
        chk("nobypass_vld", o_alloc_vld, 1);
        chk("nobypass_tag", o_alloc_tag, 7);
        chk("nobypass_freed", o_freed_tag, 7);
        chk("nobypass_cnt", o_free_cnt, 1);

        step(0, 1, 1, 40, 5);
        chk("r5a_fv", o_freed_vld, 1);
        chk("r5a_tag", o_freed_tag, 5);
        step(0, 1, 1, 41, 5);
        chk("r5b_tag", o_freed_tag, 40);
        step(0, 1, 1, 50, 0);
        chk("r0_tag", o_freed_tag, 50);
        step(0, 0, 0, 0, 0);
        chk("pulse_one_cycle", o_freed_vld, 0);
        step(1, 0, 0, 0, 0);
        chk("pre_rst_cnt", o_free_cnt, 3);

        // reset mid-stream
        rstn = 0;
        #1;
        chk("mid_rst_cnt", o_free_cnt, 32);
        chk("mid_rst_fv", o_freed_vld, 0);
        chk("mid_rst_tag", o_alloc_tag, 32);
        model_reset();
        @(negedge clk) rstn = 1;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32, 9);
        chk("rrat_identity", o_freed_tag, 9);
        chk("rrat_id_cnt", o_free_cnt, 31);

        // down to 10, then sustained push+pop across pointer wrap
        for (int i = 0; i < 21; i++) step(1, 0, 0, 0, 0);
        chk("cnt10", o_free_cnt, 10);
        for (int i = 0; i < 64; i++) begin
            retire_inflight(1);
            chk("steady_cnt", o_free_cnt, 10);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) retire_inflight($urandom_range(0, 9) < 6);
            else step($urandom_range(0, 9) < 6, $urandom_range(0, 1), 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32i_phys_reg_free_list.md
RV32I_PHYS_REG_FREE_LIST -- requirements
Module: rv32i_phys_reg_free_list

Interface
REQ-001 SHALL have parameter PHYS_REG_FILE_DEPTH, default 2**PHYS_REG_FILE_IDX_BW (64), total physical registers.
REQ-002 SHALL have parameter ARCH_REG_FILE_DEPTH, default 2**ARCH_REG_FILE_IDX_BW (32), architectural registers.
REQ-003 SHALL have port clk  in  1  single clock for all state.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_alloc_req  in  1  dispatcher requests one free physical tag this cycle.
REQ-006 SHALL have port o_alloc_vld  out  1  a free tag is available; alloc fires when i_alloc_req & o_alloc_vld.
REQ-007 SHALL have port o_alloc_tag  out  PHYS_REG_FILE_IDX_BW  head of free list, combinational, valid when o_alloc_vld.
REQ-008 SHALL have port i_retire  in  1  retire pulse from the reorder buffer.
REQ-009 SHALL have port i_retire_dst_vld  in  1  retiring instruction writes a destination.
REQ-010 SHALL have port i_retire_dst_phys_rf_tag  in  PHYS_REG_FILE_IDX_BW  new committed physical tag.
REQ-011 SHALL have port i_retire_dst_arch_rf_idx  in  ARCH_REG_FILE_IDX_BW  committed architectural index.
REQ-012 SHALL have port o_freed_vld  out  1  registered pulse: a tag was returned to the free list.
REQ-013 SHALL have port o_freed_tag  out  PHYS_REG_FILE_IDX_BW  tag returned, qualified by o_freed_vld.
REQ-014 SHALL have port o_free_cnt  out  PHYS_REG_FILE_IDX_BW+1  number of tags currently in the free list.

Function
REQ-015 SHALL hold a retirement RAT (RRAT) of ARCH_REG_FILE_DEPTH entries, entry i = committed physical tag of arch reg i.
REQ-016 SHALL hold a circular free-list FIFO of FL_DEPTH = PHYS_REG_FILE_DEPTH - ARCH_REG_FILE_DEPTH entries, with wrap-bit pointers (index width + 1).
REQ-017 SHALL pop the head and advance rd pointer on the clk edge where i_alloc_req & o_alloc_vld; zero-cycle latency for o_alloc_tag.
REQ-018 SHALL drive o_alloc_vld = (o_free_cnt != 0); no bypass of a same-cycle push into an empty list.
REQ-019 On i_retire & i_retire_dst_vld & arch idx != 0: SHALL write RRAT[idx] <= new tag and push old RRAT[idx] to the tail.
REQ-020 On i_retire & i_retire_dst_vld & arch idx == 0: SHALL leave RRAT unchanged and push i_retire_dst_phys_rf_tag itself (no leak).
REQ-021 On i_retire & !i_retire_dst_vld, or !i_retire: SHALL push nothing and leave RRAT unchanged.
REQ-022 SHALL assert o_freed_vld / o_freed_tag one cycle after each push, for one cycle per push.
REQ-023 Simultaneous push and pop SHALL both take effect; o_free_cnt unchanged.
REQ-024 o_free_cnt SHALL increment on push-only, decrement on pop-only, update registered on the same edge as the pointers.
REQ-025 Push when o_free_cnt == FL_DEPTH (not simultaneously popping) is illegal; SHALL be dropped and flagged by a simulation assertion.
REQ-026 Same-cycle retires to the same arch idx do not occur (one retire per cycle); back-to-back retires to one idx SHALL see the prior write.

Reset
REQ-027 On rstn low, SHALL asynchronously set RRAT[i] = i for all i.
REQ-028 On rstn low, SHALL fill the free list with tags ARCH_REG_FILE_DEPTH .. PHYS_REG_FILE_DEPTH-1 in ascending order, rd pointer 0, o_free_cnt = FL_DEPTH.
REQ-029 On rstn low, SHALL clear o_freed_vld and o_freed_tag to 0; reset mid-operation SHALL discard all in-flight state.

Structure
REQ-030 PHYS_REG_FILE_IDX_BW, ARCH_REG_FILE_IDX_BW and a derived FREE_LIST_DEPTH constant SHALL live in rv32i_pkg.
REQ-031 The free-list FIFO SHALL be one sub-module, rv32i_tag_fifo, with reset-time preload; RRAT stays in the top module.

Verification (PHYS 64, ARCH 32)
REQ-032 Reset release -> o_free_cnt=32, o_alloc_vld=1, o_alloc_tag=32; 32 back-to-back allocs return 32..63 then o_alloc_vld=0.
REQ-033 Retire dst_vld, arch 5, phys 40 after reset -> next cycle o_freed_vld=1, o_freed_tag=5, RRAT[5]=40; then arch 5, phys 41 -> o_freed_tag=40.
REQ-034 Retire arch 0, phys 50, dst_vld -> o_freed_tag=50, RRAT[0] stays 0.
REQ-035 List empty, same cycle alloc req + retire freeing tag 7 -> o_alloc_vld=0 that cycle, next cycle o_alloc_vld=1, o_alloc_tag=7.
REQ-036 Count 10, alloc and retire same cycle -> o_free_cnt stays 10; pointers wrap correctly after 64 cycles of sustained push/pop.
REQ-037 Assert rstn mid-stream with count 3 -> immediately o_free_cnt=32, o_freed_vld=0, RRAT identity.
